// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier.
// It produces the full 2*WIDTH-bit product of a and b, in unsigned or
// two's-complement mode. Each clock retires STEP bits of the multiplier.
// Handshake: start is accepted in IDLE, busy is high while the operation runs,
// and done is a one-cycle pulse when l_m, r_m and ovf are valid.
module seq_multiplier #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] l_m,
    output logic [WIDTH-1:0] r_m,
    output logic             ovf
);

    // Number of RUN cycles, product width and internal field widths.
    localparam int N   = WIDTH / STEP;
    localparam int PW  = 2 * WIDTH;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int SHW = $clog2(PW);

    localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
    localparam logic [PW-1:0]    ACC_ONE  = PW'(1'b1);
    localparam logic [WIDTH-1:0] OP_ONE   = WIDTH'(1'b1);

    // Reject parameter combinations the datapath is not built for.
    generate
        if (!((STEP == 1) || (STEP == 2) || (STEP == 4)) || ((WIDTH % STEP) != 0)) begin : g_bad_param
            $error("seq_multiplier: STEP must be 1, 2 or 4 and must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Magnitude of an operand. -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still
    // fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] f_magnitude(input logic [WIDTH-1:0] v,
                                                     input logic             is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = ~v + OP_ONE;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Multiplicand times one STEP-bit multiplier digit, built from shifted adds.
    function automatic logic [PW-1:0] f_partial(input logic [WIDTH-1:0] mcand,
                                                input logic [STEP-1:0]  digit);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < STEP; i++) begin
            if (digit[i]) begin
                acc = acc + ({{WIDTH{1'b0}}, mcand} << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Overflow test: the upper half must be zero (unsigned) or a pure
    // sign extension of the lower half (signed).
    function automatic logic f_overflow(input logic [PW-1:0] res,
                                        input logic          is_signed);
        logic o;
        if (is_signed) begin
            o = (res[PW-1:WIDTH] != {WIDTH{res[WIDTH-1]}});
        end else begin
            o = (res[PW-1:WIDTH] != {WIDTH{1'b0}});
        end
        return o;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic             r_signed;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_l_m;
    logic [WIDTH-1:0] r_r_m;
    logic             r_ovf;
    logic             r_done;
    logic             r_busy;

    logic             w_last_step;
    logic [SHW-1:0]   w_shift;
    logic [PW-1:0]    w_partial;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_result;
    logic             w_ovf;

    assign w_last_step = (r_count == CNT_LAST);

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: IDLE -> RUN for N cycles -> FIX for one cycle -> IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last_step) begin
                    w_next_state = S_FIX;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Partial product of this cycle, placed at its bit weight count*STEP.
    always_comb begin
        w_shift   = SHW'(r_count) * SHW'(STEP);
        w_partial = f_partial(r_mcand, r_mplier[STEP-1:0]);
        w_addend  = w_partial << w_shift;
    end

    // Sign correction modulo 2^(2*WIDTH). A zero magnitude stays zero, so the
    // sign flag needs no special case for zero operands.
    always_comb begin
        if (r_neg) begin
            w_result = ~r_acc + ACC_ONE;
        end else begin
            w_result = r_acc;
        end
        w_ovf = f_overflow(w_result, r_signed);
    end

    // Operand capture, accumulation, and result/handshake registers.
    // The result registers change only at the FIX edge, so they hold their
    // value while the next operation runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_l_m    <= '0;
            r_r_m    <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= f_magnitude(a, signed_mode);
                        r_mplier <= f_magnitude(b, signed_mode);
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_signed <= signed_mode;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc    <= r_acc + w_addend;
                    r_mplier <= r_mplier >> STEP;
                    r_count  <= r_count + CNT_ONE;
                    r_busy   <= 1'b1;
                end
                S_FIX: begin
                    r_l_m  <= w_result[WIDTH-1:0];
                    r_r_m  <= w_result[PW-1:WIDTH];
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign l_m  = r_l_m;
    assign r_m  = r_r_m;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier.
// Stimulus pushes expected results into scoreboard queues. Monitors pop one
// entry on each done pulse and compare the product, the overflow flag and the
// latency.
// One instance with default parameters runs the directed scenarios, and nine
// instances run randomized operands for each WIDTH x STEP combination.
module tb_seq_multiplier;

    typedef struct {
        logic [63:0] prod;
        bit          ovf;
        int          k;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks     = 0;
    int errors     = 0;
    int sweep_done = 0;

    function automatic void check1(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Reference: true integer product reduced modulo 2^(2w), with overflow
    // defined as the product lying outside the w-bit range of the mode.
    function automatic void ref_mul(input int w, input bit sm, input logic [31:0] av,
                                    input logic [31:0] bv, output logic [63:0] prod, output bit ov);
        longint      sa, sb, sp, lim;
        logic [63:0] ua, ub, up, mask;
        mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        ua = {32'd0, av};
        ub = {32'd0, bv};
        if (sm) begin
            sa = $signed(ua << (64 - w));
            sa = sa >>> (64 - w);
            sb = $signed(ub << (64 - w));
            sb = sb >>> (64 - w);
            sp = sa * sb;
            lim = $signed(64'd1 << (w - 1));
            ov = (sp >= lim) || (sp < -lim);
            prod = $unsigned(sp) & mask;
        end else begin
            up = ua * ub;
            ov = ((up >> w) != 64'd0);
            prod = up & mask;
        end
    endfunction

    // ---------------- directed instance (WIDTH=16, STEP=1) ----------------
    logic        rst_m, start_m, sm_m, busy_m, done_m, ovf_m;
    logic [15:0] a_m, b_m, l_m_m, r_m_m;
    exp_t        q_m[$];

    seq_multiplier #(.WIDTH(16), .STEP(1)) u_dut (
        .clk(clk), .rst(rst_m), .start(start_m), .signed_mode(sm_m),
        .a(a_m), .b(b_m), .busy(busy_m), .done(done_m),
        .l_m(l_m_m), .r_m(r_m_m), .ovf(ovf_m)
    );

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (done_m) begin
            if (q_m.size() == 0) begin
                check1("main_unexpected_done", 64'(done_m), 64'd0);
            end else begin
                e = q_m.pop_front();
                check1("main_product", {32'd0, r_m_m, l_m_m}, e.prod);
                check1("main_ovf", 64'(ovf_m), 64'(e.ovf));
                check1("main_latency", 64'(cyc - e.k), 64'd17);
            end
        end
    end

    task automatic issue_m(input bit sm, input logic [15:0] av, input logic [15:0] bv,
                           input bit push, input logic [31:0] prod, input bit ov);
        exp_t e;
        logic [31:0] r;
        start_m = 1'b1;
        sm_m = sm;
        a_m = av;
        b_m = bv;
        if (push) begin
            e.prod = {32'd0, prod};
            e.ovf = ov;
            e.k = cyc + 1;
            q_m.push_back(e);
        end
        @(negedge clk);
        start_m = 1'b0;
        r = $urandom;
        a_m = r[15:0];
        b_m = r[31:16];
        sm_m = r[0];
    endtask

    task automatic wait_idle_m(input string name);
        int n;
        n = 0;
        while (busy_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1(name, 64'(busy_m), 64'd0);
    endtask

    // Directed scenarios, then wait for the randomized sweep to finish.
    initial begin : stim_main
        int n;
        int seen;
        rst_m = 1'b1; start_m = 1'b0; sm_m = 1'b0; a_m = 16'd0; b_m = 16'd0;
        repeat (3) @(negedge clk);
        rst_m = 1'b0;
        @(negedge clk);
        check1("reset_busy", 64'(busy_m), 64'd0);
        check1("reset_done", 64'(done_m), 64'd0);
        check1("reset_l_m",  64'(l_m_m), 64'd0);
        check1("reset_r_m",  64'(r_m_m), 64'd0);
        check1("reset_ovf",  64'(ovf_m), 64'd0);

        issue_m(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 1'b1);
        wait_idle_m("idle_t1");
        issue_m(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1'b0);
        wait_idle_m("idle_t2a");
        issue_m(1'b1, 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 1'b0);
        wait_idle_m("idle_t2b");
        issue_m(1'b1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b1);
        wait_idle_m("idle_t3a");
        issue_m(1'b0, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b1);
        wait_idle_m("idle_t3b");
        issue_m(1'b1, 16'h0000, 16'h8000, 1'b1, 32'h0000_0000, 1'b0);
        wait_idle_m("idle_zero");
        issue_m(1'b1, 16'hFFFF, 16'h0005, 1'b1, 32'hFFFF_FFFB, 1'b0);
        wait_idle_m("idle_neg");

        // A start pulse during RUN must be dropped; a start in the done cycle is taken.
        issue_m(1'b0, 16'h0003, 16'h0005, 1'b1, 32'h0000_000F, 1'b0);
        repeat (3) @(negedge clk);
        start_m = 1'b1; sm_m = 1'b0; a_m = 16'h7777; b_m = 16'h7777;
        @(negedge clk);
        start_m = 1'b0;
        n = 0;
        while (!done_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        check1("t4_done_seen", 64'(done_m), 64'd1);
        issue_m(1'b1, 16'h1234, 16'hFFFE, 1'b1, 32'hFFFF_DB98, 1'b0);
        check1("b2b_busy", 64'(busy_m), 64'd1);
        repeat (4) @(negedge clk);
        check1("hold_l_m", 64'(l_m_m), 64'h000F);
        check1("hold_r_m", 64'(r_m_m), 64'h0000);
        wait_idle_m("idle_t4");

        // Asynchronous reset in the middle of RUN.
        issue_m(1'b1, 16'h1111, 16'h2222, 1'b0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_m = 1'b1;
        #1;
        check1("arst_busy", 64'(busy_m), 64'd0);
        check1("arst_done", 64'(done_m), 64'd0);
        check1("arst_l_m",  64'(l_m_m), 64'd0);
        check1("arst_r_m",  64'(r_m_m), 64'd0);
        check1("arst_ovf",  64'(ovf_m), 64'd0);
        @(negedge clk);
        rst_m = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_m) seen++;
        end
        check1("no_done_after_reset", 64'(seen), 64'd0);

        n = 0;
        while (sweep_done < 9 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check1("sweep_complete", 64'(sweep_done), 64'd9);
        check1("main_queue_drained", 64'(q_m.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- randomized sweep: WIDTH 8/16/32 x STEP 1/2/4 ----------------
    for (genvar gi = 0; gi < 9; gi++) begin : g_sw
        localparam int W  = (gi < 3) ? 8 : ((gi < 6) ? 16 : 32);
        localparam int S  = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 4);
        localparam int NS = W / S;

        logic         rst_s, start_s, sm_s, busy_s, done_s, ovf_s;
        logic [W-1:0] a_s, b_s, l_s, r_s;
        exp_t         q[$];

        seq_multiplier #(.WIDTH(W), .STEP(S)) u_dut (
            .clk(clk), .rst(rst_s), .start(start_s), .signed_mode(sm_s),
            .a(a_s), .b(b_s), .busy(busy_s), .done(done_s),
            .l_m(l_s), .r_m(r_s), .ovf(ovf_s)
        );

        function automatic logic [31:0] pick_op();
            logic [31:0] mask;
            logic [31:0] v;
            mask = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);
            case ($urandom_range(0, 7))
                0:       v = 32'd0;
                1:       v = mask;
                2:       v = 32'd1 << (W - 1);
                3:       v = (32'd1 << (W - 1)) - 32'd1;
                4:       v = 32'd1;
                default: v = $urandom & mask;
            endcase
            return v;
        endfunction

        always @(negedge clk) begin : mon
            exp_t e;
            if (done_s) begin
                if (q.size() == 0) begin
                    $display("FAIL sweep W%0d S%0d unexpected done: got done=1 expected 0", W, S);
                    checks++;
                    errors++;
                end else begin
                    e = q.pop_front();
                    checks++;
                    if ((64'({r_s, l_s}) !== e.prod) || (ovf_s !== e.ovf) || ((cyc - e.k) != NS + 1)) begin
                        errors++;
                        $display("FAIL sweep W%0d S%0d: got prod %h ovf %0d lat %0d expected prod %h ovf %0d lat %0d",
                                 W, S, 64'({r_s, l_s}), ovf_s, cyc - e.k, e.prod, e.ovf, NS + 1);
                    end
                end
            end
        end

        initial begin : stim
            int          n;
            logic [31:0] av, bv, r;
            bit          sm, ov;
            logic [63:0] p;
            exp_t        e;
            rst_s = 1'b1; start_s = 1'b0; sm_s = 1'b0; a_s = '0; b_s = '0;
            repeat (3) @(negedge clk);
            rst_s = 1'b0;
            for (int t = 0; t < 500; t++) begin
                n = 0;
                while (busy_s && n < 200) begin
                    r = $urandom;
                    start_s = (r[2:0] == 3'd0);
                    a_s = r[W-1:0];
                    r = $urandom;
                    b_s = r[W-1:0];
                    sm_s = r[0];
                    @(negedge clk);
                    n++;
                end
                start_s = 1'b0;
                if (busy_s) begin
                    $display("FAIL sweep W%0d S%0d busy timeout: got busy=1 expected 0", W, S);
                    checks++;
                    errors++;
                    break;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                av = pick_op();
                bv = pick_op();
                sm = 1'($urandom_range(0, 1));
                ref_mul(W, sm, av, bv, p, ov);
                start_s = 1'b1;
                sm_s = sm;
                a_s = av[W-1:0];
                b_s = bv[W-1:0];
                e.prod = p;
                e.ovf = ov;
                e.k = cyc + 1;
                q.push_back(e);
                @(negedge clk);
                start_s = 1'b0;
            end
            n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check1($sformatf("sweep_W%0d_S%0d_drained", W, S), 64'(q.size()), 64'd0);
            sweep_done++;
        end
    end

endmodule
